// File: rtl/spectro_readout_scheduler.sv
// Frame-level readout scheduler: a frame timer starts a scan that loads and streams each
// enabled channel's word over a valid/ready serial link, then clears the channel counters.
module spectro_readout_scheduler #(
  parameter int NUM_CH   = 16,
  parameter int WORD_W   = 12,
  parameter int PERIOD_W = 16,
  localparam int SEL_W   = $clog2(NUM_CH),
  localparam int BIT_W   = $clog2(WORD_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic                ovr_clr,
  output logic [SEL_W-1:0]    sel,
  output logic                load,
  output logic                bit_valid,
  input  logic                bit_ready,
  output logic                shift_en,
  output logic                word_last,
  output logic                clr_counters,
  output logic                busy,
  output logic                overrun,
  output logic [7:0]          frame_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CLEAR} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] timer;
  logic [NUM_CH-1:0]   mask_q;
  logic [BIT_W-1:0]    bitcnt;
  logic                tick;
  logic                last_bit;
  logic                nxt_found;
  logic [SEL_W-1:0]    nxt_sel;
  logic [SEL_W-1:0]    low_sel;

  assign tick = enable && (timer == period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                timer <= '0;
    else if (!enable || tick) timer <= '0;
    else                      timer <= timer + 1'b1;
  end

  // Descending scan: the last hit written is the lowest qualifying index.
  always_comb begin
    nxt_found = 1'b0;
    nxt_sel   = '0;
    low_sel   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel))) begin
        nxt_found = 1'b1;
        nxt_sel   = SEL_W'(i);
      end
      if (ch_mask[i]) low_sel = SEL_W'(i);
    end
  end

  assign load         = (state == LOAD);
  assign bit_valid    = (state == SHIFT);
  assign clr_counters = (state == CLEAR);
  assign busy         = (state != IDLE);
  assign last_bit     = (bitcnt == BIT_W'(WORD_W - 1));
  assign shift_en     = bit_valid & bit_ready;
  assign word_last    = shift_en & last_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      bitcnt    <= '0;
      mask_q    <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      // A tick during a scan is dropped, only flagged; set beats clear.
      if (tick && state != IDLE) overrun <= 1'b1;
      else if (ovr_clr)          overrun <= 1'b0;

      case (state)
        IDLE: if (tick) begin
          mask_q <= ch_mask;
          if (|ch_mask) begin
            sel   <= low_sel;
            state <= LOAD;
          end else begin
            state <= CLEAR;
          end
        end
        LOAD: begin
          bitcnt <= '0;
          state  <= SHIFT;
        end
        SHIFT: if (bit_ready) begin
          if (last_bit) begin
            if (nxt_found) begin
              sel   <= nxt_sel;
              state <= LOAD;
            end else begin
              state <= CLEAR;
            end
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end
        CLEAR: begin
          frame_cnt <= frame_cnt + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spectro_readout_scheduler.sv
// Directed bench for spectro_readout_scheduler: expected channel order is queued when a
// frame is started and checked as each load strobe appears.
module tb_spectro_readout_scheduler;

  localparam int NUM_CH = 16, WORD_W = 12, PERIOD_W = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic [PERIOD_W-1:0] period = '0;
  logic [NUM_CH-1:0]   ch_mask = '0;
  logic                ovr_clr = 1'b0;
  logic                bit_ready = 1'b1;
  logic [3:0]          sel;
  logic                load, bit_valid, shift_en, word_last, clr_counters, busy, overrun;
  logic [7:0]          frame_cnt;

  spectro_readout_scheduler #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period), .ch_mask(ch_mask),
    .ovr_clr(ovr_clr), .sel(sel), .load(load), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .shift_en(shift_en), .word_last(word_last),
    .clr_counters(clr_counters), .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  int cyc = 0;
  int n_load, n_shift, n_last, n_clr, wshift, clr_cyc;
  int load_cyc[$];
  int exp_sel[$];
  logic       prev_stall = 1'b0;
  logic [3:0] stall_sel = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic reset_counts();
    n_load = 0; n_shift = 0; n_last = 0; n_clr = 0; wshift = 0; clr_cyc = 0;
    load_cyc.delete();
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_sel.push_back(i);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_clr(input string tag, input int budget, input bit toggle);
    int start = n_clr;
    int k = 0;
    while (n_clr == start && k < budget) begin
      @(posedge clk); #1;
      if (toggle) bit_ready = ~bit_ready;
      k++;
    end
    bit_ready = 1'b1;
    chk(tag, n_clr - start, 1);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (prev_stall) chk("stall_sel", sel, stall_sel);
    prev_stall = bit_valid & !bit_ready;
    stall_sel  = sel;
    if (load) begin
      logic [31:0] e;
      e = (exp_sel.size() != 0) ? exp_sel.pop_front() : 32'hDEAD;
      chk("load_sel", sel, e);
      n_load++;
      wshift = 0;
      load_cyc.push_back(cyc);
    end
    if (shift_en) begin
      n_shift++;
      wshift++;
    end
    if (word_last) begin
      n_last++;
      chk("bits_per_word", wshift, WORD_W);
      wshift = 0;
    end
    if (clr_counters) begin
      n_clr++;
      clr_cyc = cyc;
    end
  end

  initial begin
    int t0, saved;
    int exp_fc;
    bit found;
    exp_fc = 0;
    reset_counts();

    // Reset state
    step(2);
    @(negedge clk);
    chk("reset_outs", {sel, load, bit_valid, shift_en, word_last, clr_counters, busy,
                       overrun, frame_cnt}, 0);
    step(1);
    reset = 1'b0;
    step(2);

    // T1: full mask, long period
    reset_counts();
    push_range(0, 15);
    period = 16'd299; ch_mask = 16'hFFFF; bit_ready = 1'b1;
    t0 = cyc; enable = 1'b1;
    wait_clr("t1_clr", 700, 1'b0);
    enable = 1'b0; exp_fc++;
    chk("t1_loads", n_load, 16);
    chk("t1_shifts", n_shift, 192);
    chk("t1_lasts", n_last, 16);
    chk("t1_first_load_lat", load_cyc[0] - t0, 300);
    for (int i = 1; i < load_cyc.size(); i++) chk("t1_load_gap", load_cyc[i] - load_cyc[i-1], 13);
    chk("t1_clr_after_last", clr_cyc - load_cyc[15], 13);
    chk("t1_frame_cnt", frame_cnt, exp_fc);
    chk("t1_overrun", overrun, 0);
    chk("t1_idle", busy, 0);

    // T2: sparse mask
    reset_counts();
    exp_sel.push_back(0); exp_sel.push_back(5); exp_sel.push_back(10); exp_sel.push_back(15);
    ch_mask = 16'h8421; enable = 1'b1;
    wait_clr("t2_clr", 700, 1'b0);
    enable = 1'b0; exp_fc++;
    chk("t2_loads", n_load, 4);
    chk("t2_shifts", n_shift, 48);
    chk("t2_lasts", n_last, 4);
    chk("t2_clr_after_last", clr_cyc - load_cyc[3], 13);
    chk("t2_frame_cnt", frame_cnt, exp_fc);

    // T3: ready toggling every cycle
    reset_counts();
    exp_sel.push_back(1); exp_sel.push_back(3);
    ch_mask = 16'h000A; enable = 1'b1;
    wait_clr("t3_clr", 800, 1'b1);
    enable = 1'b0; exp_fc++;
    chk("t3_loads", n_load, 2);
    chk("t3_shifts", n_shift, 24);
    chk("t3_lasts", n_last, 2);
    chk("t3_frame_cnt", frame_cnt, exp_fc);

    // T4a: period shorter than a frame -> overrun, no queued second scan
    reset_counts();
    push_range(0, 15);
    period = 16'd50; ch_mask = 16'hFFFF; enable = 1'b1;
    wait_clr("t4_clr", 700, 1'b0);
    enable = 1'b0; exp_fc++;
    step(5);
    chk("t4_loads", n_load, 16);
    chk("t4_overrun_set", overrun, 1);
    chk("t4_idle", busy, 0);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    chk("t4_overrun_clr", overrun, 0);

    // T4b: period=0 ticks every cycle; set beats concurrent clear
    reset_counts();
    push_range(0, 15);
    period = 16'd0; ovr_clr = 1'b1; enable = 1'b1;
    step(5);
    chk("t4_set_wins", overrun, 1);
    chk("t4_busy", busy, 1);
    enable = 1'b0;
    step(2);
    chk("t4_clr_after_disable", overrun, 0);
    ovr_clr = 1'b0;
    wait_clr("t4b_clr", 400, 1'b0);
    exp_fc++;
    chk("t4b_loads", n_load, 16);
    chk("t4b_frame_cnt", frame_cnt, exp_fc);

    // T5: empty mask -> straight to CLEAR
    reset_counts();
    period = 16'd3; ch_mask = '0;
    t0 = cyc; enable = 1'b1;
    wait_clr("t5_clr", 50, 1'b0);
    enable = 1'b0; exp_fc++;
    chk("t5_clr_lat", clr_cyc - t0, 4);
    chk("t5_no_load", n_load, 0);
    chk("t5_frame_cnt", frame_cnt, exp_fc);

    // T6: reset mid-shift of channel 7
    reset_counts();
    push_range(0, 7);
    period = 16'd5; ch_mask = 16'hFFFF; enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step(1);
      if (load && sel == 4'd7) found = 1'b1;
    end
    chk("t6_reach_ch7", found, 1);
    step(3);
    reset = 1'b1; #1;
    chk("t6_reset_outs", {sel, load, bit_valid, shift_en, word_last, clr_counters, busy,
                          overrun, frame_cnt}, 0);
    enable = 1'b0;
    saved = n_clr;
    step(3);
    chk("t6_no_clr", n_clr, saved);
    reset = 1'b0;
    step(1);
    reset_counts();
    push_range(0, 15);
    period = 16'd2; enable = 1'b1;
    wait_clr("t6_clr", 400, 1'b0);
    enable = 1'b0;
    chk("t6_loads", n_load, 16);
    chk("t6_frame_cnt", frame_cnt, 1);
    chk("sb_empty", exp_sel.size(), 0);

    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
